// File: rtl/fan_div_arbiter_pkg.sv
// Shared definitions for the fan-control divider arbiter.
//   - Default UFixed width and fractional bit count used by the fan datapath.
//   - Arbiter FSM state encoding (IDLE -> BUSY -> DONE -> IDLE).
package fan_div_arbiter_pkg;

  localparam int UFIX_W        = 32;
  localparam int FIX_FRAC_BITS = 16;
  localparam int DEF_N_REQ     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fan_div_arbiter_if.sv
// Requester-side bus of the shared fan-control divider.
//   req_in       per-requester request level
//   dividend_in  packed dividends, requester i at [i*WIDTH +: WIDTH]
//   divisor_in   packed divisors, same packing
//   gnt_out      one-hot grant, high for the whole operation
//   done_out     one-hot 1-cycle completion pulse
//   quotient_out result, valid with done_out and held until the next done
//   busy_out     arbiter is not idle
// master: the requesting compute stages; slave: the arbiter.
interface fan_div_arbiter_if
  import fan_div_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = UFIX_W
);
  logic [N_REQ-1:0]       req_in;
  logic [N_REQ*WIDTH-1:0] dividend_in;
  logic [N_REQ*WIDTH-1:0] divisor_in;
  logic [N_REQ-1:0]       gnt_out;
  logic [N_REQ-1:0]       done_out;
  logic [WIDTH-1:0]       quotient_out;
  logic                   busy_out;

  modport master (
    output req_in, dividend_in, divisor_in,
    input  gnt_out, done_out, quotient_out, busy_out
  );

  modport slave (
    input  req_in, dividend_in, divisor_in,
    output gnt_out, done_out, quotient_out, busy_out
  );
endinterface

// File: rtl/fan_div_arbiter_serial_divider.sv
// Iterative restoring radix-2 unsigned fixed-point divider.
//   quotient = (dividend << FRAC_BITS) / divisor, saturated to all-ones.
//   One quotient bit per cycle, WIDTH+FRAC_BITS cycles per operation;
//   a zero divisor finishes after a single cycle with an all-ones result.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (control only)
//   start_i        1-cycle pulse; operands are captured on this edge
//   dividend_i     UFixed dividend
//   divisor_i      UFixed divisor
//   last_o         high in the final working cycle (result lands next edge)
//   valid_o        1-cycle pulse, quotient_o valid in this cycle
//   quotient_o     saturated UFixed quotient
module fan_div_arbiter_serial_divider
  import fan_div_arbiter_pkg::*;
#(
  parameter int WIDTH     = UFIX_W,
  parameter int FRAC_BITS = FIX_FRAC_BITS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o
);
  localparam int NW   = WIDTH + FRAC_BITS;
  localparam int ITER = NW;
  localparam int CW   = $clog2(ITER + 1);

  // Control state
  logic          run_q;
  logic          dz_q;
  logic          valid_q;
  logic [CW-1:0] cnt_q;

  // Datapath state; num_q shifts the numerator out of its top while the
  // quotient bits shift in at the bottom, so it ends holding the quotient.
  logic [NW-1:0]    num_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] quot_q;

  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [NW-1:0]    num_nx;

  function automatic logic [WIDTH-1:0] sat_quot(input logic [NW-1:0] q);
    if ((q >> WIDTH) != '0) begin
      return '1;
    end
    return q[WIDTH-1:0];
  endfunction

  // One restoring step: bring down the next numerator bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, num_q[NW-1]};
    ge     = (rem_sh >= {1'b0, div_q});
    rem_nx = ge ? WIDTH'(rem_sh - {1'b0, div_q}) : rem_sh[WIDTH-1:0];
    num_nx = {num_q[NW-2:0], ge};
  end

  assign last_o = run_q && (dz_q || (cnt_q == CW'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q   <= 1'b0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (start_i) begin
        run_q <= 1'b1;
        dz_q  <= (divisor_i == '0);
        cnt_q <= CW'(ITER);
      end else if (run_q) begin
        cnt_q <= cnt_q - CW'(1);
        if (last_o) begin
          run_q   <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i) begin
      num_q <= NW'(dividend_i) << FRAC_BITS;
      rem_q <= '0;
      div_q <= divisor_i;
    end else if (run_q) begin
      num_q <= num_nx;
      rem_q <= rem_nx;
      if (last_o) begin
        quot_q <= dz_q ? '1 : sat_quot(num_nx);
      end
    end
  end

  assign valid_o    = valid_q;
  assign quotient_o = quot_q;
endmodule

// File: rtl/fan_div_arbiter.sv
// Round-robin arbiter sharing one serial divider among the fan-control
// stages (temperature smoothing, PWM linearisation, PWM smoothing).
// Ports:
//   clk_in_100  system clock
//   rst_in      synchronous active-high reset; drops any operation in flight
//   bus         requester bus (slave side): req/operands in,
//               grant/done/quotient/busy out
// A requester that drops req while its operation is running gets no done
// pulse and leaves quotient_out untouched; the divider still runs to the end.
module fan_div_arbiter
  import fan_div_arbiter_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int WIDTH     = UFIX_W,
  parameter int FRAC_BITS = FIX_FRAC_BITS
) (
  input  logic             clk_in_100,
  input  logic             rst_in,
  fan_div_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] win_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic             abort_q;
  logic [WIDTH-1:0] qhold_q;

  logic [IDX_W-1:0] pick_idx;
  logic             any_req;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;
  logic [N_REQ-1:0] win_onehot;
  logic             start;
  logic             upd;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic [WIDTH-1:0] quot;

  logic             div_last;
  logic             div_valid;
  logic [WIDTH-1:0] div_quot;

  // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    any_req  = 1'b0;
    pick_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_in[(int'(rr_ptr_q) + k) % N_REQ]) begin
        any_req  = 1'b1;
        pick_idx = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_dividend = bus.dividend_in[i*WIDTH +: WIDTH];
        sel_divisor  = bus.divisor_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_onehot[i] = (win_q == IDX_W'(i));
    end
  end

  // FSM: state register
  always_ff @(posedge clk_in_100) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req)  state_d = ST_BUSY;
      ST_BUSY: if (div_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    start = (state_q == ST_IDLE) && any_req;
    upd   = (state_q == ST_DONE) && div_valid && !abort_q;
    gnt   = (state_q != ST_IDLE) ? win_onehot : '0;
    done  = upd ? win_onehot : '0;
    quot  = upd ? div_quot : qhold_q;
  end

  always_ff @(posedge clk_in_100) begin
    if (rst_in) begin
      win_q    <= '0;
      rr_ptr_q <= '0;
      abort_q  <= 1'b0;
      qhold_q  <= '0;
    end else begin
      if (start) begin
        win_q    <= pick_idx;
        rr_ptr_q <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        abort_q  <= 1'b0;
      end else if ((state_q == ST_BUSY) && ((bus.req_in & win_onehot) == '0)) begin
        abort_q <= 1'b1;
      end
      if (upd) begin
        qhold_q <= div_quot;
      end
    end
  end

  fan_div_arbiter_serial_divider #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_div (
    .clk_i      (clk_in_100),
    .rst_i      (rst_in),
    .start_i    (start),
    .dividend_i (sel_dividend),
    .divisor_i  (sel_divisor),
    .last_o     (div_last),
    .valid_o    (div_valid),
    .quotient_o (div_quot)
  );

  assign bus.gnt_out      = gnt;
  assign bus.done_out     = done;
  assign bus.quotient_out = quot;
  assign bus.busy_out     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fan_div_arbiter.sv
module tb_fan_div_arbiter;
  localparam int NR = 3;
  localparam int W  = 32;
  localparam int FB = 16;

  typedef struct {
    int          idx;
    logic [31:0] q;
  } exp_t;

  logic clk;
  logic rst;

  fan_div_arbiter_if #(.N_REQ(NR), .WIDTH(W)) bus ();

  fan_div_arbiter #(.N_REQ(NR), .WIDTH(W), .FRAC_BITS(FB)) dut (
    .clk_in_100 (clk),
    .rst_in     (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  int          rr_model = 0;
  logic [31:0] model_q  = '0;
  logic [31:0] op_a [NR];
  logic [31:0] op_b [NR];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: exact quotient of the fixed-point values, saturated to 32 bits.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] num;
    logic [63:0] q;
    if (b == 0) return 32'hFFFF_FFFF;
    num = {32'b0, a} << FB;
    q   = num / {32'b0, b};
    if (q > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  function automatic int pick_model(input logic [NR-1:0] m);
    for (int k = 0; k < NR; k++) begin
      if (m[(rr_model + k) % NR]) return (rr_model + k) % NR;
    end
    return -1;
  endfunction

  function automatic void expect_op(input int w);
    exp_t e;
    e.idx = w;
    e.q   = ref_div(op_a[w], op_b[w]);
    sb.push_back(e);
    model_q  = e.q;
    rr_model = (w + 1) % NR;
  endfunction

  // Scoreboard monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    check("gnt_onehot0", 64'($onehot0(bus.gnt_out)), 64'd1);
    if (bus.done_out != '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done_out=%b, expected 000", bus.done_out);
      end else begin
        mon_e = sb.pop_front();
        check("done_idx", 64'(bus.done_out), 64'(1) << mon_e.idx);
        check("quotient", 64'(bus.quotient_out), 64'(mon_e.q));
      end
    end
  end

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      bus.dividend_in[i*W +: W] = op_a[i];
      bus.divisor_in[i*W +: W]  = op_b[i];
    end
  endtask

  // Requesters in mask raise req together; each drops it on its own done.
  task automatic run_group(input logic [NR-1:0] mask, output logic [NR-1:0] gnt1, output int first_done);
    logic [NR-1:0] pend;
    int w;
    pend = mask;
    while (pend != '0) begin
      w = pick_model(pend);
      expect_op(w);
      pend[w] = 1'b0;
    end
    @(negedge clk);
    drive_ops();
    bus.req_in = mask;
    gnt1       = '0;
    first_done = -1;
    for (int cyc = 1; cyc <= 60 * NR + 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) gnt1 = bus.gnt_out;
      if (bus.done_out != '0 && first_done < 0) first_done = cyc;
      bus.req_in = bus.req_in & ~bus.done_out;
      if (bus.req_in == '0) break;
    end
    check("group_timeout_reqs_left", 64'(bus.req_in), 64'd0);
    bus.req_in = '0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  logic [NR-1:0] g1;
  int            fd;
  int            ndone;
  logic          saw_done;
  logic          busy49;
  logic          busy50;

  initial begin
    rst             = 1'b1;
    bus.req_in      = '0;
    bus.dividend_in = '0;
    bus.divisor_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 64'(bus.gnt_out), 64'd0);
    check("rst_done", 64'(bus.done_out), 64'd0);
    check("rst_quot", 64'(bus.quotient_out), 64'd0);
    check("rst_busy", 64'(bus.busy_out), 64'd0);
    rst = 1'b0;

    // All three held: grants 0,1,2,0.
    op_a[0] = 32'h0003_0000; op_b[0] = 32'h0002_0000;
    op_a[1] = 32'h0007_8000; op_b[1] = 32'h0000_4000;
    op_a[2] = 32'h00C8_0000; op_b[2] = 32'h0019_0000;
    for (int n = 0; n < 4; n++) expect_op(pick_model(3'b111));
    @(negedge clk);
    drive_ops();
    bus.req_in = 3'b111;
    ndone = 0;
    for (int cyc = 1; cyc <= 400 && ndone < 4; cyc++) begin
      @(negedge clk);
      if (bus.done_out != '0) ndone++;
    end
    bus.req_in = '0;
    check("held_done_count", 64'(ndone), 64'd4);

    // Single req0 10.0/20.0.
    op_a[0] = 32'h000A_0000; op_b[0] = 32'h0014_0000;
    run_group(3'b001, g1, fd);
    check("t1_gnt_T1", 64'(g1), 64'b001);
    check("t1_done_lat", 64'(fd), 64'd49);

    // Divisor zero on req1.
    op_a[1] = 32'h1234_5678; op_b[1] = 32'h0;
    run_group(3'b010, g1, fd);
    check("t3_gnt_T1", 64'(g1), 64'b010);
    check("t3_done_lat", 64'(fd), 64'd2);

    // Saturation and unity.
    op_a[0] = 32'hFFFF_0000; op_b[0] = 32'h0000_0001;
    run_group(3'b001, g1, fd);
    check("t4_sat_lat", 64'(fd), 64'd49);
    op_a[0] = 32'h0001_0000; op_b[0] = 32'h0001_0000;
    run_group(3'b001, g1, fd);
    check("t4_unity_lat", 64'(fd), 64'd49);

    // Abort: req2 dropped mid-operation.
    op_a[2] = 32'h0050_0000; op_b[2] = 32'h0003_0000;
    @(negedge clk);
    drive_ops();
    bus.req_in = 3'b100;
    rr_model   = 0;
    saw_done   = 1'b0;
    busy49     = 1'b0;
    busy50     = 1'b1;
    for (int cyc = 1; cyc <= 56; cyc++) begin
      @(negedge clk);
      if (cyc == 20) bus.req_in = '0;
      if (bus.done_out != '0) saw_done = 1'b1;
      if (cyc == 49) busy49 = bus.busy_out;
      if (cyc == 50) busy50 = bus.busy_out;
    end
    check("t5_no_done", 64'(saw_done), 64'd0);
    check("t5_busy_T49", 64'(busy49), 64'd1);
    check("t5_busy_T50", 64'(busy50), 64'd0);
    check("t5_quot_held", 64'(bus.quotient_out), 64'(model_q));

    // Randomized groups.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NR; i++) begin
        op_a[i] = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> 12);
        case ($urandom_range(0, 4))
          0:       op_b[i] = 32'h0;
          1:       op_b[i] = 32'($urandom_range(1, 4));
          2:       op_b[i] = $urandom;
          3:       op_b[i] = $urandom >> 12;
          default: op_b[i] = op_a[i];
        endcase
      end
      run_group(3'($urandom_range(1, 7)), g1, fd);
    end

    // Reset during an operation on req1, then req1 and req2 together.
    op_a[1] = 32'h0020_0000; op_b[1] = 32'h0004_0000;
    @(negedge clk);
    drive_ops();
    bus.req_in = 3'b010;
    repeat (10) @(negedge clk);
    rst        = 1'b1;
    bus.req_in = '0;
    @(negedge clk);
    check("t6_rst_gnt", 64'(bus.gnt_out), 64'd0);
    check("t6_rst_done", 64'(bus.done_out), 64'd0);
    check("t6_rst_busy", 64'(bus.busy_out), 64'd0);
    check("t6_rst_quot", 64'(bus.quotient_out), 64'd0);
    rst      = 1'b0;
    rr_model = 0;
    model_q  = '0;
    op_a[1] = 32'h0009_0000; op_b[1] = 32'h0003_0000;
    op_a[2] = 32'h0001_0000; op_b[2] = 32'h0004_0000;
    run_group(3'b110, g1, fd);
    check("t6_first_gnt", 64'(g1), 64'b010);

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
